// File: rtl/action_sequencer_pkg.sv
// action_sequencer_pkg
// Shared types and constants for the ALU action sequencer.
//   action_state_t : sequencer FSM state encoding (3 bits)
//   OPCOUNT_W      : width of the completed-operation counter
//   max_int        : helper used to size the shared wait/latency counter
package action_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    FIRE      = 3'd2,
    EXEC      = 3'd3,
    HOLD      = 3'd4
  } action_state_t;

  localparam int OPCOUNT_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/action_timer.sv
// action_timer
// Loadable up/down counter shared by the data-wait timeout and the ALU
// latency countdown.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, clears the count
//   clear_i    : synchronous clear to zero
//   load_i     : load load_val_i (priority below clear)
//   load_val_i : value to load
//   inc_i      : count up by one
//   dec_i      : count down by one (inc_i wins if both set)
//   term_val_i : terminal value to compare against
//   at_term_o  : current count equals term_val_i
module action_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic [W-1:0] term_val_i,
  output logic         at_term_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)      count_d = '0;
    else if (load_i)  count_d = load_val_i;
    else if (inc_i)   count_d = count_q + W'(1);
    else if (dec_i)   count_d = count_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign at_term_o = (count_q == term_val_i);

endmodule

// File: rtl/action_sequencer.sv
// action_sequencer
// Sequences one ALU operation at a time: waits for op and operands, issues a
// one-cycle action strobe, tracks the fixed ALU latency, then holds
// result-valid until the consumer accepts it. All outputs are registered.
//   i_Clock, i_Reset : clock and synchronous active-high reset
//   i_ALUOpReady     : decoded op pending
//   i_DataReady      : operands present
//   i_Abort          : flush current op (ignored while holding a result)
//   i_ResultAccept   : consumer takes the result
//   o_Action         : one-cycle strobe, high only in FIRE
//   o_Busy           : state is not IDLE
//   o_ResultValid    : high in HOLD
//   o_Timeout        : one-cycle pulse in the IDLE cycle after a wait expires
//   o_OpCount        : accepted operations, wraps
//   o_DbgState       : current FSM state for observation
//
// Handshake: the result transfers on any cycle where o_ResultValid and
// i_ResultAccept are both high; o_ResultValid stays high until that happens.
module action_sequencer
  import action_sequencer_pkg::*;
#(
  parameter int ALU_LATENCY = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_ALUOpReady,
  input  logic                 i_DataReady,
  input  logic                 i_Abort,
  input  logic                 i_ResultAccept,
  output logic                 o_Action,
  output logic                 o_Busy,
  output logic                 o_ResultValid,
  output logic                 o_Timeout,
  output logic [OPCOUNT_W-1:0] o_OpCount,
  output action_state_t        o_DbgState
);

  localparam int CW = $clog2(max_int(TIMEOUT, ALU_LATENCY) + 1);

  action_state_t state_q, state_d;

  logic          tmr_clear, tmr_load, tmr_inc, tmr_dec;
  logic [CW-1:0] tmr_term;
  logic          tmr_at_term;
  logic          timeout_d;
  logic          accept_d;

  action_timer #(.W(CW)) u_timer (
    .clk_i      (i_Clock),
    .rst_i      (i_Reset),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (CW'(ALU_LATENCY - 1)),
    .inc_i      (tmr_inc),
    .dec_i      (tmr_dec),
    .term_val_i (tmr_term),
    .at_term_o  (tmr_at_term)
  );

  always_comb begin
    state_d   = state_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;
    tmr_dec   = 1'b0;
    tmr_term  = '0;
    timeout_d = 1'b0;
    accept_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ALUOpReady && i_DataReady) begin
          state_d = FIRE;
        end else if (i_ALUOpReady) begin
          state_d   = WAIT_DATA;
          tmr_clear = 1'b1;
        end
      end
      WAIT_DATA: begin
        tmr_term = CW'(TIMEOUT - 1);
        // Data in the last wait cycle beats the timeout.
        if (i_Abort) begin
          state_d = IDLE;
        end else if (i_DataReady) begin
          state_d = FIRE;
        end else if (tmr_at_term) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      FIRE: begin
        tmr_load = 1'b1;
        state_d  = i_Abort ? IDLE : EXEC;
      end
      EXEC: begin
        if (i_Abort) begin
          state_d = IDLE;
        end else if (tmr_at_term) begin
          state_d = HOLD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLD: begin
        if (i_ResultAccept) begin
          accept_d = 1'b1;
          if (i_ALUOpReady && i_DataReady) begin
            state_d = FIRE;
          end else if (i_ALUOpReady) begin
            state_d   = WAIT_DATA;
            tmr_clear = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q       <= IDLE;
      o_Action      <= 1'b0;
      o_Busy        <= 1'b0;
      o_ResultValid <= 1'b0;
      o_Timeout     <= 1'b0;
      o_OpCount     <= '0;
    end else begin
      state_q       <= state_d;
      o_Action      <= (state_d == FIRE);
      o_Busy        <= (state_d != IDLE);
      o_ResultValid <= (state_d == HOLD);
      o_Timeout     <= timeout_d;
      if (accept_d) o_OpCount <= o_OpCount + OPCOUNT_W'(1);
    end
  end

  assign o_DbgState = state_q;

endmodule

// File: tb/tb_action_sequencer.sv
module tb_action_sequencer;
  import action_sequencer_pkg::*;

  localparam int L  = 3;
  localparam int TO = 15;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, op = 1'b0, data = 1'b0, abort_i = 1'b0, accept = 1'b0;
  logic act, busy, rv, tmo;
  logic [7:0] cnt;
  action_state_t dbg;

  action_sequencer #(.ALU_LATENCY(L), .TIMEOUT(TO)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_ALUOpReady   (op),
    .i_DataReady    (data),
    .i_Abort        (abort_i),
    .i_ResultAccept (accept),
    .o_Action       (act),
    .o_Busy         (busy),
    .o_ResultValid  (rv),
    .o_Timeout      (tmo),
    .o_OpCount      (cnt),
    .o_DbgState     (dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 waiting for data, 2 running.
  // While running, age counts cycles since the strobe: 0 is the strobe cycle,
  // 1..L are ALU latency cycles, beyond L the result is held.
  int  m_mode = 0, m_waited = 0, m_age = 0;
  bit  m_to = 0, model_on = 0;
  int  m_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_to = 0; m_count = 0; model_on = 1;
    end else begin
      m_to = 0;
      case (m_mode)
        0: if (op) begin
             if (data) begin m_mode = 2; m_age = 0; end
             else begin m_mode = 1; m_waited = 0; end
           end
        1: if (abort_i) m_mode = 0;
           else if (data) begin m_mode = 2; m_age = 0; end
           else if (m_waited + 1 == TO) begin m_mode = 0; m_to = 1; end
           else m_waited++;
        default: begin
          if (m_age <= L) begin
            if (abort_i) m_mode = 0;
            else m_age++;
          end else if (accept) begin
            m_count = (m_count + 1) % 256;
            if (op && data) m_age = 0;
            else if (op) begin m_mode = 1; m_waited = 0; end
            else m_mode = 0;
          end
        end
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    if (model_on) begin
      check("cmp_action", act,  (m_mode == 2 && m_age == 0));
      check("cmp_busy",   busy, (m_mode != 0));
      check("cmp_rvalid", rv,   (m_mode == 2 && m_age > L));
      check("cmp_tmo",    tmo,  m_to);
      check("cmp_count",  cnt,  m_count[7:0]);
    end
  end

  // driver
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick(2);
    check("rst_action", act, 0);
    check("rst_busy", busy, 0);
    check("rst_rvalid", rv, 0);
    check("rst_tmo", tmo, 0);
    check("rst_count", cnt, 0);
    check("rst_state", dbg, 0);
    rst = 1'b0;
    tick(1);

    // T1: op and data together (cycle 0)
    op = 1; data = 1;
    tick(1);                                 // cycle 1
    check("t1_action_c1", act, 1);
    check("t1_busy_c1", busy, 1);
    op = 0; data = 0;
    tick(1);                                 // cycle 2
    check("t1_action_c2", act, 0);
    tick(2);                                 // cycle 4
    check("t1_rvalid_c4", rv, 0);
    tick(1);                                 // cycle 5
    check("t1_rvalid_c5", rv, 1);
    accept = 1;
    tick(1);                                 // cycle 6
    accept = 0;
    check("t1_count_c6", cnt, 1);
    check("t1_busy_c6", busy, 0);

    // T2: data arrives 4 cycles after op
    op = 1; data = 0;
    tick(1);                                 // cycle 1, WAIT_DATA
    op = 0;
    tick(3);                                 // cycle 4
    data = 1;
    check("t2_action_c4", act, 0);
    tick(1);                                 // cycle 5
    data = 0;
    check("t2_action_c5", act, 1);
    tick(4);                                 // cycle 9
    check("t2_rvalid", rv, 1);
    accept = 1;
    tick(1);
    accept = 0;
    check("t2_count", cnt, 2);

    // T3: data never arrives
    op = 1;
    tick(1);                                 // cycle 1
    op = 0;
    tick(14);                                // cycle 15
    check("t3_busy_c15", busy, 1);
    check("t3_tmo_c15", tmo, 0);
    tick(1);                                 // cycle 16
    check("t3_tmo_c16", tmo, 1);
    check("t3_busy_c16", busy, 0);
    check("t3_count", cnt, 2);
    tick(1);
    check("t3_tmo_c17", tmo, 0);

    // T4: abort in second EXEC cycle
    op = 1; data = 1;
    tick(1);                                 // cycle 1 FIRE
    op = 0; data = 0;
    tick(2);                                 // cycle 3 EXEC #2
    abort_i = 1;
    tick(1);
    abort_i = 0;
    check("t4_busy", busy, 0);
    tick(5);
    check("t4_rvalid", rv, 0);
    check("t4_count", cnt, 2);

    // T4b: abort during wait, abort during FIRE
    op = 1; tick(2); op = 0; abort_i = 1; tick(1); abort_i = 0;
    check("t4b_busy", busy, 0);
    op = 1; data = 1; tick(1); op = 0; data = 0; abort_i = 1; tick(1); abort_i = 0;
    check("t4c_busy", busy, 0);
    tick(6);
    check("t4c_count", cnt, 2);

    // T5: back-to-back, 300 accepted ops from reset
    rst = 1; tick(1); rst = 0;
    op = 1; data = 1; accept = 1;            // cycle 0
    tick(5);                                 // cycle 5 HOLD
    check("t5_rvalid_c5", rv, 1);
    tick(1);                                 // cycle 6 FIRE again
    check("t5_action_c6", act, 1);
    check("t5_count_c6", cnt, 1);
    tick(1494);                              // cycle 1500, HOLD of op 300
    check("t5_rvalid_c1500", rv, 1);
    op = 0; data = 0;
    tick(1);
    accept = 0;
    check("t5_count_wrap", cnt, 44);
    check("t5_busy_end", busy, 0);

    // T6: reset during HOLD and during WAIT_DATA
    op = 1; data = 1; tick(1); op = 0; data = 0;
    tick(4);
    check("t6_rvalid_hold", rv, 1);
    rst = 1; tick(1); rst = 0;
    check("t6_rvalid_after", rv, 0);
    check("t6_busy_after", busy, 0);
    check("t6_count_after", cnt, 0);
    accept = 1; tick(1); accept = 0;
    check("t6_count_ignored", cnt, 0);
    op = 1; tick(3); op = 0;
    check("t6_busy_wait", busy, 1);
    rst = 1; tick(1); rst = 0;
    check("t6_busy_rst_wait", busy, 0);
    check("t6_tmo_rst_wait", tmo, 0);
    tick(20);
    check("t6_tmo_later", tmo, 0);
    check("t6_count_end", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
